// File: rtl/ahb_lite_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_decoder_if
//  Purpose  : AHB-Lite master-side bus and per-slave response bundle for the
//             address decoder / response multiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_lite_decoder_if;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [3:0]   hsel;
  logic         hready;
  logic [31:0]  hrdata;
  logic         hresp;
  logic [127:0] s_hrdata;
  logic [3:0]   s_hreadyout;
  logic [3:0]   s_hresp;

  // Environment side: bus master plus the slave response sources.
  modport master (
    output haddr, htrans, hwrite, s_hrdata, s_hreadyout, s_hresp,
    input  hsel, hready, hrdata, hresp
  );

  // Decoder side.
  modport slave (
    input  haddr, htrans, hwrite, s_hrdata, s_hreadyout, s_hresp,
    output hsel, hready, hrdata, hresp
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_decoder
//  Purpose  : Single-master AHB-Lite address decoder, data-phase response mux
//             and built-in default slave returning two-cycle ERROR.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_F000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h4000_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_F000,
  parameter logic [31:0] S3_BASE = 32'h4000_1000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_F000
) (
  input  logic              clk,
  input  logic              reset,
  ahb_lite_decoder_if.slave bus
);

  localparam int          c_nslv = 4;
  localparam logic [127:0] c_base = {S3_BASE, S2_BASE, S1_BASE, S0_BASE};
  localparam logic [127:0] c_mask = {S3_MASK, S2_MASK, S1_MASK, S0_MASK};

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  logic [c_nslv-1:0] w_match;
  logic [c_nslv-1:0] w_hsel;
  logic              w_unmapped;
  logic              w_active;
  logic              w_err_req;
  logic              w_unused;

  logic [c_nslv:0]   r_dsel;
  ds_state_t         r_ds_state;
  logic              r_ds_hready;
  logic              r_ds_hresp;

  // ---------------------------------------------------------------- decode
  for (genvar gi = 0; gi < c_nslv; gi++) begin : g_match
    assign w_match[gi] = (bus.haddr & c_mask[32*gi +: 32]) == c_base[32*gi +: 32];
  end

  // Walk from the highest index down so the lowest matching slave wins.
  always_comb begin
    w_hsel = '0;
    for (int i = c_nslv - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hsel    = '0;
        w_hsel[i] = 1'b1;
      end
    end
  end

  assign bus.hsel   = w_hsel;
  assign w_unmapped = ~|w_match;
  assign w_active   = bus.htrans[1];
  assign w_err_req  = bus.hready & w_active & w_unmapped;

  // Write direction and the SEQ/NONSEQ distinction do not affect decode.
  assign w_unused = &{bus.hwrite, bus.htrans[0]};

  // ------------------------------------------------- data-phase select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dsel <= '0;
    end else if (bus.hready) begin
      r_dsel <= w_active ? {w_unmapped, w_hsel} : '0;
    end
  end

  // --------------------------------------------------- default slave FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ds_state  <= DS_IDLE;
      r_ds_hready <= 1'b1;
      r_ds_hresp  <= 1'b0;
    end else begin
      case (r_ds_state)
        DS_IDLE: begin
          if (w_err_req) begin
            r_ds_state  <= DS_ERR1;
            r_ds_hready <= 1'b0;
            r_ds_hresp  <= 1'b1;
          end
        end
        DS_ERR1: begin
          r_ds_state  <= DS_ERR2;
          r_ds_hready <= 1'b1;
          r_ds_hresp  <= 1'b1;
        end
        DS_ERR2: begin
          if (w_err_req) begin
            r_ds_state  <= DS_ERR1;
            r_ds_hready <= 1'b0;
            r_ds_hresp  <= 1'b1;
          end else begin
            r_ds_state  <= DS_IDLE;
            r_ds_hready <= 1'b1;
            r_ds_hresp  <= 1'b0;
          end
        end
        default: begin
          r_ds_state  <= DS_IDLE;
          r_ds_hready <= 1'b1;
          r_ds_hresp  <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------ response mux
  // An empty data phase reads as a zero-wait OKAY.
  always_comb begin
    bus.hrdata = '0;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    for (int i = 0; i < c_nslv; i++) begin
      if (r_dsel[i]) begin
        bus.hrdata = bus.s_hrdata[32*i +: 32];
        bus.hready = bus.s_hreadyout[i];
        bus.hresp  = bus.s_hresp[i];
      end
    end
    if (r_dsel[c_nslv]) begin
      bus.hready = r_ds_hready;
      bus.hresp  = r_ds_hresp;
    end
  end

`ifndef SYNTHESIS
  a_dsel_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(r_dsel));
  a_hsel_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.hsel));
  a_err1_stall:  assert property (@(posedge clk) disable iff (!reset)
                   (r_ds_state == DS_ERR1) |-> (r_dsel[c_nslv] && !bus.hready && bus.hresp));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_decoder
//  Purpose  : Self-checking bench for ahb_lite_decoder: decode table, directed
//             multi-cycle sequences and randomized traffic against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_decoder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ahb_lite_decoder_if ifc  ();
  ahb_lite_decoder_if ifc2 ();

  ahb_lite_decoder u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  ahb_lite_decoder #(.S3_BASE(32'h4000_0000)) u_dut_ovl (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  exp_hsel;
  } vec_t;

  logic [31:0] m_base [4];
  logic [31:0] m_mask [4];
  int          m_sel;    // -1 none, 0..3 slave, 4 default slave
  int          m_errph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    ifc.haddr  = a;
    ifc.htrans = t;
  endtask

  task automatic set_rdata(input int idx, input logic [31:0] v);
    ifc.s_hrdata[32*idx +: 32] = v;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return 4;
  endfunction

  function automatic logic [3:0] ref_hsel(input logic [31:0] a);
    int s;
    logic [3:0] h;
    s = ref_decode(a);
    h = '0;
    if (s < 4) h[s] = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000 | ($urandom & 32'h0000_0FFF);
      1:       return 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
      2:       return 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
      3:       return 32'h2001_0000 | ($urandom & 32'h0000_FFFF);
      4:       return 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
      5:       return 32'h4000_1000 | ($urandom & 32'h0000_0FFF);
      6:       return 32'h4000_2000 | ($urandom & 32'h0000_0FFF);
      default: return $urandom;
    endcase
  endfunction

  // Compare against the transfer-level model, then advance it to the next edge.
  task automatic model_check_and_step();
    logic [31:0] e_rdata;
    logic        e_ready;
    logic        e_resp;
    e_rdata = 32'h0;
    e_ready = 1'b1;
    e_resp  = 1'b0;
    if (m_sel >= 0 && m_sel < 4) begin
      e_rdata = ifc.s_hrdata[32*m_sel +: 32];
      e_ready = ifc.s_hreadyout[m_sel];
      e_resp  = ifc.s_hresp[m_sel];
    end else if (m_sel == 4) begin
      e_ready = (m_errph == 2);
      e_resp  = 1'b1;
    end
    chk("rnd_hsel",   {28'h0, ifc.hsel}, {28'h0, ref_hsel(ifc.haddr)});
    chk("rnd_hready", {31'h0, ifc.hready}, {31'h0, e_ready});
    chk("rnd_hresp",  {31'h0, ifc.hresp},  {31'h0, e_resp});
    chk("rnd_hrdata", ifc.hrdata, e_rdata);
    if (e_ready) begin
      m_sel   = ifc.htrans[1] ? ref_decode(ifc.haddr) : -1;
      m_errph = 1;
    end else if (m_sel == 4) begin
      m_errph = 2;
    end
  endtask

  vec_t vecs [13];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_base = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h4000_1000};
    m_mask = '{32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};

    vecs[0]  = '{32'h0000_0000, 2'd2, 4'b0001};
    vecs[1]  = '{32'h0000_0FFF, 2'd0, 4'b0001};
    vecs[2]  = '{32'h0000_1000, 2'd2, 4'b0000};
    vecs[3]  = '{32'h2000_0000, 2'd3, 4'b0010};
    vecs[4]  = '{32'h2000_FFFC, 2'd1, 4'b0010};
    vecs[5]  = '{32'h2001_0000, 2'd2, 4'b0000};
    vecs[6]  = '{32'h4000_0000, 2'd0, 4'b0100};
    vecs[7]  = '{32'h4000_0FFF, 2'd2, 4'b0100};
    vecs[8]  = '{32'h4000_1000, 2'd2, 4'b1000};
    vecs[9]  = '{32'h4000_1FFC, 2'd3, 4'b1000};
    vecs[10] = '{32'h4000_2000, 2'd2, 4'b0000};
    vecs[11] = '{32'hFFFF_FFFF, 2'd0, 4'b0000};
    vecs[12] = '{32'h1FFF_FFFF, 2'd2, 4'b0000};

    reset            = 1'b0;
    ifc.haddr        = 32'h2000_0000;
    ifc.htrans       = 2'd0;
    ifc.hwrite       = 1'b0;
    ifc.s_hrdata     = {4{32'hCAFE_F00D}};
    ifc.s_hreadyout  = 4'b0000;
    ifc.s_hresp      = 4'b1111;
    ifc2.haddr       = 32'h0;
    ifc2.htrans      = 2'd0;
    ifc2.hwrite      = 1'b0;
    ifc2.s_hrdata    = '0;
    ifc2.s_hreadyout = 4'b1111;
    ifc2.s_hresp     = 4'b0000;

    // Reset: idle outputs even with all slaves stalling; hsel still decodes.
    tick();
    tick();
    @(negedge clk);
    chk("rst_hready", {31'h0, ifc.hready}, 32'h1);
    chk("rst_hresp",  {31'h0, ifc.hresp},  32'h0);
    chk("rst_hrdata", ifc.hrdata, 32'h0);
    chk("rst_hsel",   {28'h0, ifc.hsel}, 32'h2);
    tick();
    ifc.s_hreadyout = 4'b1111;
    ifc.s_hresp     = 4'b0000;
    reset           = 1'b1;

    // Decode table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].addr, vecs[i].trans);
      @(negedge clk);
      chk($sformatf("tbl_hsel[%0d]", i), {28'h0, ifc.hsel}, {28'h0, vecs[i].exp_hsel});
      tick();
    end
    drive(32'h0, 2'd0);
    do_reset();

    // ROM read.
    set_rdata(0, 32'hDEAD_BEEF);
    drive(32'h0000_0010, 2'd2);
    @(negedge clk);
    chk("rom_hsel", {28'h0, ifc.hsel}, 32'h1);
    tick();
    drive(32'h0, 2'd0);
    @(negedge clk);
    chk("rom_hrdata", ifc.hrdata, 32'hDEAD_BEEF);
    chk("rom_hready", {31'h0, ifc.hready}, 32'h1);
    tick();

    // Wait-state hold with master changing address.
    set_rdata(0, 32'hAAAA_0000);
    set_rdata(1, 32'h1111_1111);
    ifc.s_hreadyout = 4'b1101;
    drive(32'h2000_0000, 2'd2);
    @(negedge clk);
    chk("ws_hsel", {28'h0, ifc.hsel}, 32'h2);
    tick();
    drive(32'h0000_0000, 2'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ws_wait[%0d]", k), {31'h0, ifc.hready}, 32'h0);
      tick();
    end
    ifc.s_hreadyout = 4'b1111;
    @(negedge clk);
    chk("ws_done_hready", {31'h0, ifc.hready}, 32'h1);
    chk("ws_done_hrdata", ifc.hrdata, 32'h1111_1111);
    tick();
    drive(32'h0, 2'd0);
    @(negedge clk);
    chk("ws_next_hrdata", ifc.hrdata, 32'hAAAA_0000);
    tick();

    // Unmapped NONSEQ: two-cycle ERROR, then OKAY after IDLE.
    drive(32'h8000_0000, 2'd2);
    @(negedge clk);
    chk("um_hsel", {28'h0, ifc.hsel}, 32'h0);
    tick();
    drive(32'h8000_0000, 2'd0);
    @(negedge clk);
    chk("um_err1", {30'h0, ifc.hready, ifc.hresp}, 32'h1);
    tick();
    @(negedge clk);
    chk("um_err2", {30'h0, ifc.hready, ifc.hresp}, 32'h3);
    tick();
    @(negedge clk);
    chk("um_okay", {30'h0, ifc.hready, ifc.hresp}, 32'h2);
    tick();

    // Unmapped IDLE and BUSY stay zero-wait OKAY.
    drive(32'h8000_0000, 2'd0);
    tick();
    drive(32'h8000_0000, 2'd1);
    @(negedge clk);
    chk("um_idle", {30'h0, ifc.hready, ifc.hresp}, 32'h2);
    tick();
    drive(32'h0, 2'd0);
    @(negedge clk);
    chk("um_busy", {30'h0, ifc.hready, ifc.hresp}, 32'h2);
    tick();

    // Pipelined pair, slave 3 then slave 2.
    set_rdata(2, 32'h2222_2222);
    set_rdata(3, 32'h3333_3333);
    drive(32'h4000_1000, 2'd2);
    @(negedge clk);
    chk("pp_hsel3", {28'h0, ifc.hsel}, 32'h8);
    tick();
    drive(32'h4000_0004, 2'd2);
    @(negedge clk);
    chk("pp_hsel2", {28'h0, ifc.hsel}, 32'h4);
    chk("pp_data3", ifc.hrdata, 32'h3333_3333);
    tick();
    drive(32'h0, 2'd0);
    @(negedge clk);
    chk("pp_data2", ifc.hrdata, 32'h2222_2222);
    tick();

    // Overlapping windows: lowest index wins.
    ifc2.haddr = 32'h4000_0004;
    #1;
    chk("ovl_hsel", {28'h0, ifc2.hsel}, 32'h4);
    ifc2.haddr = 32'h4000_1000;
    #1;
    chk("ovl_hole", {28'h0, ifc2.hsel}, 32'h0);

    // Reset mid slave wait state: outputs idle without a clock edge.
    ifc.s_hreadyout = 4'b1101;
    drive(32'h2000_0000, 2'd2);
    tick();
    drive(32'h0, 2'd0);
    @(negedge clk);
    chk("mr_pre_hrdata", ifc.hrdata, 32'h1111_1111);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_hready", {31'h0, ifc.hready}, 32'h1);
    chk("mr_hrdata", ifc.hrdata, 32'h0);
    tick();
    ifc.s_hreadyout = 4'b1111;
    reset = 1'b1;

    // Reset during default-slave ERROR.
    drive(32'h8000_0000, 2'd2);
    tick();
    drive(32'h0, 2'd0);
    @(negedge clk);
    chk("mr_err1", {30'h0, ifc.hready, ifc.hresp}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_err_idle", {30'h0, ifc.hready, ifc.hresp}, 32'h2);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic against the model.
    do_reset();
    m_sel   = -1;
    m_errph = 0;
    for (int c = 0; c < 3000; c++) begin
      ifc.haddr       = rand_addr();
      ifc.htrans      = 2'($urandom_range(0, 3));
      ifc.hwrite      = 1'($urandom_range(0, 1));
      ifc.s_hrdata    = {$urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < 4; s++) begin
        ifc.s_hreadyout[s] = ($urandom_range(0, 3) != 0);
        ifc.s_hresp[s]     = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      model_check_and_step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
